// File: rtl/sram_port_arbiter_if.sv
// Pipelined Avalon-MM-style command/response port between one master and the SRAM arbiter.
interface sram_port_arbiter_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BE_W   = DATA_W / 8
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic              readdatavalid;
  logic [DATA_W-1:0] readdata;

  // Requesting side (camera pixel path, CPU data path)
  modport master (
    output read, write, address, byteenable, writedata,
    input  waitrequest, readdatavalid, readdata
  );

  // Arbiter side
  modport slave (
    input  read, write, address, byteenable, writedata,
    output waitrequest, readdatavalid, readdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-master round-robin arbiter with a command stage (C) and a response-tag stage (R)
// in front of a single-port synchronous SRAM with one cycle of read latency.
module sram_port_arbiter #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BE_W   = DATA_W / 8
) (
  input  logic               clk,
  input  logic               reset,
  sram_port_arbiter_if.slave m0,
  sram_port_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]  sram_address,
  output logic [BE_W-1:0]    sram_byteenable,
  output logic               sram_chipselect,
  output logic               sram_write,
  output logic [DATA_W-1:0]  sram_writedata,
  output logic               sram_clken,
  input  logic [DATA_W-1:0]  sram_readdata
);

  logic              w_req0;
  logic              w_req1;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_acc0;
  logic              w_acc1;
  logic              w_acc;
  logic [ADDR_W-1:0] w_addr;
  logic [BE_W-1:0]   w_be;
  logic [DATA_W-1:0] w_wdata;
  logic              w_wr;

  logic              r_last;
  logic [ADDR_W-1:0] r_addr;
  logic [BE_W-1:0]   r_be;
  logic [DATA_W-1:0] r_wdata;
  logic              r_cs;
  logic              r_wr;
  logic              r_id;
  logic              r_rvalid;
  logic              r_rid;

  assign w_req0 = m0.read | m0.write;
  assign w_req1 = m1.read | m1.write;

  // Round-robin grant: a lone requester wins; on a tie the master other than r_last wins
  assign w_gnt0 = w_req0 & (~w_req1 | r_last);
  assign w_gnt1 = w_req1 & ~w_gnt0;

  // Stall whenever requesting without the grant, and unconditionally while in reset
  assign m0.waitrequest = reset | (w_req0 & ~w_gnt0);
  assign m1.waitrequest = reset | (w_req1 & ~w_gnt1);

  assign w_acc0 = w_req0 & ~m0.waitrequest;
  assign w_acc1 = w_req1 & ~m1.waitrequest;
  assign w_acc  = w_acc0 | w_acc1;

  // Select the accepted master's command fields
  always_comb begin
    w_addr  = m0.address;
    w_be    = m0.byteenable;
    w_wdata = m0.writedata;
    w_wr    = m0.write;
    if (w_acc1) begin
      w_addr  = m1.address;
      w_be    = m1.byteenable;
      w_wdata = m1.writedata;
      w_wr    = m1.write;
    end
  end

  // Round-robin history: remembers the master of the most recent accepted command
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last <= 1'b1;
    end else if (w_acc) begin
      r_last <= w_acc1;
    end
  end

  // Stage C: command register that drives the SRAM port directly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_cs    <= 1'b0;
      r_wr    <= 1'b0;
      r_id    <= 1'b0;
    end else if (w_acc) begin
      r_addr  <= w_addr;
      r_be    <= w_wr ? w_be : {BE_W{1'b1}};
      r_wdata <= w_wdata;
      r_cs    <= 1'b1;
      r_wr    <= w_wr;
      r_id    <= w_acc1;
    end else begin
      r_cs    <= 1'b0;
      r_wr    <= 1'b0;
    end
  end

  // Stage R: tags the SRAM read data returning this cycle with its owner
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rvalid <= 1'b0;
      r_rid    <= 1'b0;
    end else begin
      r_rvalid <= r_cs & ~r_wr;
      r_rid    <= r_id;
    end
  end

  assign sram_address    = r_addr;
  assign sram_byteenable = r_be;
  assign sram_chipselect = r_cs;
  assign sram_write      = r_wr;
  assign sram_writedata  = r_wdata;
  assign sram_clken      = 1'b1;

  // Read return: the SRAM's unregistered output goes straight to the tagged master
  assign m0.readdatavalid = r_rvalid & ~r_rid;
  assign m1.readdatavalid = r_rvalid & r_rid;
  assign m0.readdata      = sram_readdata;
  assign m1.readdata      = sram_readdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed vector table, hand-written
// reset/contention sequences and randomized traffic against a transaction-level model.
module tb_sram_port_arbiter;

  logic        clk;
  logic        reset;
  logic [11:0] sram_address;
  logic [3:0]  sram_byteenable;
  logic        sram_chipselect;
  logic        sram_write;
  logic [31:0] sram_writedata;
  logic        sram_clken;
  logic [31:0] sram_readdata;

  sram_port_arbiter_if m0_if ();
  sram_port_arbiter_if m1_if ();

  sram_port_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .m0              (m0_if),
    .m1              (m1_if),
    .sram_address    (sram_address),
    .sram_byteenable (sram_byteenable),
    .sram_chipselect (sram_chipselect),
    .sram_write      (sram_write),
    .sram_writedata  (sram_writedata),
    .sram_clken      (sram_clken),
    .sram_readdata   (sram_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int unsigned i);
    return (i * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // SRAM behavioural model: 4096 x 32, byte-lane writes, one cycle read latency
  logic [31:0] sram_mem [4096];
  logic [31:0] sram_tmp;
  bit          mem_ready;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 4096; i++) sram_mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (sram_chipselect && sram_clken) begin
      if (sram_write) begin
        sram_tmp = sram_mem[sram_address];
        for (int b = 0; b < 4; b++)
          if (sram_byteenable[b]) sram_tmp[8*b +: 8] = sram_writedata[8*b +: 8];
        sram_mem[sram_address] <= sram_tmp;
      end else begin
        sram_readdata <= sram_mem[sram_address];
      end
    end
  end

  // ---------------- reference model (transaction level) ----------------
  typedef struct {
    int unsigned due;
    logic [31:0] data;
  } rsp_t;

  logic [31:0] ref_mem [4096];
  rsp_t        q0 [$];
  rsp_t        q1 [$];
  bit          m_last;
  bit          acc0;
  bit          acc1;
  bit          pw_v;
  logic [11:0] pw_a;
  logic [3:0]  pw_be;
  logic [31:0] pw_d;
  int unsigned cyc;
  int unsigned n_chk;
  int unsigned n_fail;
  int unsigned rsp_cnt0;
  int unsigned rsp_cnt1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_m0(input logic r, input logic w, input logic [11:0] a,
                        input logic [3:0] be, input logic [31:0] d);
    m0_if.read = r; m0_if.write = w; m0_if.address = a;
    m0_if.byteenable = be; m0_if.writedata = d;
  endtask

  task automatic set_m1(input logic r, input logic w, input logic [11:0] a,
                        input logic [3:0] be, input logic [31:0] d);
    m1_if.read = r; m1_if.write = w; m1_if.address = a;
    m1_if.byteenable = be; m1_if.writedata = d;
  endtask

  // First half of a cycle: predict grant/stall and responses, compare at the falling edge
  task automatic half_a();
    bit req0, req1, ev0, ev1;
    @(negedge clk);
    req0 = m0_if.read || m0_if.write;
    req1 = m1_if.read || m1_if.write;
    if (reset) begin
      q0.delete(); q1.delete();
      pw_v = 1'b0; m_last = 1'b1; acc0 = 1'b0; acc1 = 1'b0;
      chk1("model m0_waitrequest", m0_if.waitrequest, 1'b1);
      chk1("model m1_waitrequest", m1_if.waitrequest, 1'b1);
    end else begin
      if (req0 && req1) begin
        acc0 = (m_last == 1'b1);
        acc1 = !acc0;
      end else begin
        acc0 = req0;
        acc1 = req1;
      end
      chk1("model m0_waitrequest", m0_if.waitrequest, req0 && !acc0);
      chk1("model m1_waitrequest", m1_if.waitrequest, req1 && !acc1);
    end
    ev0 = (q0.size() > 0) && (q0[0].due == cyc);
    ev1 = (q1.size() > 0) && (q1[0].due == cyc);
    chk1("model m0_readdatavalid", m0_if.readdatavalid, ev0);
    chk1("model m1_readdatavalid", m1_if.readdatavalid, ev1);
    if (ev0) begin
      chk("model m0_readdata", m0_if.readdata, q0[0].data);
      void'(q0.pop_front());
      rsp_cnt0++;
    end
    if (ev1) begin
      chk("model m1_readdata", m1_if.readdata, q1[0].data);
      void'(q1.pop_front());
      rsp_cnt1++;
    end
  endtask

  // Second half: commit the accepted command to the model at the rising edge
  task automatic half_b();
    rsp_t        rsp;
    logic [11:0] a;
    @(posedge clk);
    cyc++;
    if (pw_v) begin
      for (int b = 0; b < 4; b++)
        if (pw_be[b]) ref_mem[pw_a][8*b +: 8] = pw_d[8*b +: 8];
    end
    pw_v = 1'b0;
    if (acc0 || acc1) begin
      m_last = acc1;
      if (acc1 ? m1_if.write : m0_if.write) begin
        pw_v  = 1'b1;
        pw_a  = acc1 ? m1_if.address : m0_if.address;
        pw_be = acc1 ? m1_if.byteenable : m0_if.byteenable;
        pw_d  = acc1 ? m1_if.writedata : m0_if.writedata;
      end else begin
        a        = acc1 ? m1_if.address : m0_if.address;
        rsp.due  = cyc + 1;
        rsp.data = ref_mem[a];
        if (acc1) q1.push_back(rsp);
        else      q0.push_back(rsp);
      end
    end
    #1;
  endtask

  task automatic rand_cmd(output logic r, output logic w, output logic [11:0] a,
                          output logic [3:0] be, output logic [31:0] d);
    int unsigned k;
    k  = $urandom_range(0, 9);
    r  = (k >= 4 && k <= 6);
    w  = (k >= 7);
    a  = ($urandom_range(0, 9) == 0) ? 12'hFFF : 12'($urandom_range(0, 15));
    be = 4'($urandom_range(1, 15));
    d  = $urandom;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic r0; logic w0; logic [11:0] a0; logic [3:0] be0; logic [31:0] d0;
    logic r1; logic w1; logic [11:0] a1; logic [3:0] be1; logic [31:0] d1;
    logic ew0; logic ew1; logic ev0; logic ev1; logic [31:0] ed0; logic [31:0] ed1;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vt [NVEC];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic        r0, w0, r1, w1, hold0, hold1;
    logic [11:0] a0, a1;
    logic [3:0]  be0, be1;
    logic [31:0] d0, d1;
    int unsigned i0, i1, base0, base1;
    bit          ac0, ac1;

    //            r0   w0   a0      be0   d0             r1   w1   a1      be1   d1             ew0  ew1  ev0  ev1  ed0            ed1
    vt[0]  = '{1'b0,1'b1,12'h123,4'hF,32'hDEADBEEF, 1'b0,1'b0,12'h000,4'h0,32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0};
    vt[1]  = '{1'b1,1'b0,12'h123,4'hF,32'h0,        1'b0,1'b0,12'h000,4'h0,32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0};
    vt[2]  = '{1'b0,1'b0,12'h000,4'h0,32'h0,        1'b0,1'b0,12'h000,4'h0,32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0};
    vt[3]  = '{1'b0,1'b0,12'h000,4'h0,32'h0,        1'b0,1'b0,12'h000,4'h0,32'h0,        1'b0,1'b0,1'b1,1'b0,32'hDEADBEEF, 32'h0};
    vt[4]  = '{1'b0,1'b0,12'h000,4'h0,32'h0,        1'b0,1'b1,12'hFFF,4'hF,32'h11223344, 1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0};
    vt[5]  = '{1'b0,1'b0,12'h000,4'h0,32'h0,        1'b0,1'b1,12'hFFF,4'h5,32'hAABBCCDD, 1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0};
    vt[6]  = '{1'b0,1'b0,12'h000,4'h0,32'h0,        1'b1,1'b0,12'hFFF,4'h0,32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0};
    vt[7]  = '{1'b0,1'b0,12'h000,4'h0,32'h0,        1'b0,1'b0,12'h000,4'h0,32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0};
    vt[8]  = '{1'b0,1'b0,12'h000,4'h0,32'h0,        1'b0,1'b0,12'h000,4'h0,32'h0,        1'b0,1'b0,1'b0,1'b1,32'h0,        32'h11BB33DD};
    vt[9]  = '{1'b0,1'b1,12'h010,4'hF,32'h00000055, 1'b1,1'b0,12'h010,4'h0,32'h0,        1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0};
    vt[10] = '{1'b0,1'b0,12'h000,4'h0,32'h0,        1'b1,1'b0,12'h010,4'h0,32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0};
    vt[11] = '{1'b0,1'b0,12'h000,4'h0,32'h0,        1'b0,1'b0,12'h000,4'h0,32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0};
    vt[12] = '{1'b0,1'b0,12'h000,4'h0,32'h0,        1'b0,1'b0,12'h000,4'h0,32'h0,        1'b0,1'b0,1'b0,1'b1,32'h0,        32'h00000055};

    n_chk = 0; n_fail = 0; cyc = 0; rsp_cnt0 = 0; rsp_cnt1 = 0;
    m_last = 1'b1; pw_v = 1'b0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
    reset = 1'b1;
    set_m0(1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
    set_m1(1'b0, 1'b0, 12'h0, 4'h0, 32'h0);

    // Reset held for 3 cycles: SRAM idle, no responses, both ports stalled
    for (int k = 0; k < 3; k++) begin
      half_a();
      chk1("reset sram_chipselect", sram_chipselect, 1'b0);
      chk1("reset sram_write", sram_write, 1'b0);
      chk1("reset m0_waitrequest", m0_if.waitrequest, 1'b1);
      chk1("reset m1_waitrequest", m1_if.waitrequest, 1'b1);
      chk1("reset m0_readdatavalid", m0_if.readdatavalid, 1'b0);
      chk1("reset m1_readdatavalid", m1_if.readdatavalid, 1'b0);
      half_b();
    end
    reset = 1'b0;
    half_a();
    chk1("idle m0_waitrequest", m0_if.waitrequest, 1'b0);
    chk1("idle m1_waitrequest", m1_if.waitrequest, 1'b0);
    chk1("sram_clken", sram_clken, 1'b1);
    half_b();

    // Directed table: write/read, byte lanes, same-cycle write/read hazard
    for (int i = 0; i < NVEC; i++) begin
      set_m0(vt[i].r0, vt[i].w0, vt[i].a0, vt[i].be0, vt[i].d0);
      set_m1(vt[i].r1, vt[i].w1, vt[i].a1, vt[i].be1, vt[i].d1);
      half_a();
      chk1($sformatf("vec%0d m0_waitrequest", i), m0_if.waitrequest, vt[i].ew0);
      chk1($sformatf("vec%0d m1_waitrequest", i), m1_if.waitrequest, vt[i].ew1);
      chk1($sformatf("vec%0d m0_readdatavalid", i), m0_if.readdatavalid, vt[i].ev0);
      chk1($sformatf("vec%0d m1_readdatavalid", i), m1_if.readdatavalid, vt[i].ev1);
      if (vt[i].ev0) chk($sformatf("vec%0d m0_readdata", i), m0_if.readdata, vt[i].ed0);
      if (vt[i].ev1) chk($sformatf("vec%0d m1_readdata", i), m1_if.readdata, vt[i].ed1);
      half_b();
    end

    // Contention: 8 back-to-back reads per master, grants must alternate starting with m0
    i0 = 0; i1 = 0; base0 = rsp_cnt0; base1 = rsp_cnt1;
    for (int k = 0; k < 16; k++) begin
      set_m0(i0 < 8, 1'b0, 12'h200 + 12'(i0), 4'hF, 32'h0);
      set_m1(i1 < 8, 1'b0, 12'h300 + 12'(i1), 4'hF, 32'h0);
      half_a();
      chk1("contention m0_waitrequest", m0_if.waitrequest, (i0 < 8) && (k[0] == 1'b1));
      chk1("contention m1_waitrequest", m1_if.waitrequest, (i1 < 8) && (k[0] == 1'b0));
      ac0 = (i0 < 8) && !m0_if.waitrequest;
      ac1 = (i1 < 8) && !m1_if.waitrequest;
      half_b();
      if (ac0) i0++;
      if (ac1) i1++;
    end
    set_m0(1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
    set_m1(1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
    for (int k = 0; k < 3; k++) begin half_a(); half_b(); end
    chk("contention m0 responses", 32'(rsp_cnt0 - base0), 32'd8);
    chk("contention m1 responses", 32'(rsp_cnt1 - base1), 32'd8);

    // Reset the cycle after a read is accepted: that read must never respond
    set_m0(1'b1, 1'b0, 12'h123, 4'hF, 32'h0);
    half_a(); half_b();
    set_m0(1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      half_a();
      chk1("midreset m0_readdatavalid", m0_if.readdatavalid, 1'b0);
      chk1("midreset sram_chipselect", sram_chipselect, 1'b0);
      half_b();
    end
    reset = 1'b0;
    set_m0(1'b1, 1'b0, 12'h010, 4'hF, 32'h0);
    half_a();
    chk1("postreset m0_waitrequest", m0_if.waitrequest, 1'b0);
    half_b();
    set_m0(1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
    half_a();
    chk1("postreset early m0_readdatavalid", m0_if.readdatavalid, 1'b0);
    half_b();
    half_a();
    chk1("postreset m0_readdatavalid", m0_if.readdatavalid, 1'b1);
    chk("postreset m0_readdata", m0_if.readdata, 32'h00000055);
    half_b();

    // Randomized traffic; a stalled master holds its command until accepted
    hold0 = 1'b0; hold1 = 1'b0;
    r0 = 1'b0; w0 = 1'b0; a0 = '0; be0 = '0; d0 = '0;
    r1 = 1'b0; w1 = 1'b0; a1 = '0; be1 = '0; d1 = '0;
    for (int k = 0; k < 300; k++) begin
      if (!hold0) rand_cmd(r0, w0, a0, be0, d0);
      if (!hold1) rand_cmd(r1, w1, a1, be1, d1);
      set_m0(r0, w0, a0, be0, d0);
      set_m1(r1, w1, a1, be1, d1);
      half_a();
      hold0 = (r0 || w0) && m0_if.waitrequest;
      hold1 = (r1 || w1) && m1_if.waitrequest;
      half_b();
    end
    set_m0(1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
    set_m1(1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
    for (int k = 0; k < 4; k++) begin half_a(); half_b(); end
    chk("drain m0 outstanding", 32'(q0.size()), 32'd0);
    chk("drain m1 outstanding", 32'(q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
